// File: rtl/keypad_scanner.sv
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 matrix keypad scanner with sync, debounce, one event per press.
//               Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 1000,
  parameter int REPEAT_CNT   = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] shift_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int DEB_W   = $clog2(DEBOUNCE_CNT);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CNT - 1);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;

  logic [1:0]         state;
  logic [1:0]         next_state;
  logic [3:0]         row_m;
  logic [3:0]         row_s;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         col_idx;
  logic [1:0]         cand_col;
  logic [1:0]         cand_row;
  logic [1:0]         first_row;
  logic [DEB_W-1:0]   stable_cnt;
  logic [DEB_W-1:0]   release_cnt;
  logic               cand_low;
  logic               dwell_last;
  logic               any_row;
  logic               advance_col;
  logic               latch_cand;
  logic               accept;
  logic               release_key;
  logic               repeat_fire;

  assign cand_low   = ~row_s[cand_row];
  assign dwell_last = (dwell == DWELL_LAST);
  assign any_row    = (row_s != 4'b1111);

  // Lowest-index active row wins when several are pressed together.
  always_comb begin
    first_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s[i]) first_row = 2'(i);
    end
  end

  always_comb begin
    shift_col          = 4'b1111;
    shift_col[col_idx] = 1'b0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= SCAN;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      SCAN:     if (dwell_last && any_row) next_state = DEBOUNCE;
      DEBOUNCE: begin
        if (!cand_low)                      next_state = SCAN;
        else if (stable_cnt == DEB_LAST)    next_state = HOLD;
      end
      HOLD:     if (!cand_low && release_cnt == DEB_LAST) next_state = SCAN;
      default:  next_state = SCAN;
    endcase
  end

  // Control strobes
  always_comb begin
    advance_col = 1'b0;
    latch_cand  = 1'b0;
    accept      = 1'b0;
    release_key = 1'b0;
    case (state)
      SCAN: begin
        advance_col = dwell_last && !any_row;
        latch_cand  = dwell_last && any_row;
      end
      DEBOUNCE: begin
        advance_col = !cand_low;
        accept      = cand_low && (stable_cnt == DEB_LAST);
      end
      HOLD: begin
        release_key = !cand_low && (release_cnt == DEB_LAST);
        advance_col = release_key;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_m       <= 4'b1111;
      row_s       <= 4'b1111;
      dwell       <= '0;
      col_idx     <= 2'd0;
      cand_col    <= 2'd0;
      cand_row    <= 2'd0;
      stable_cnt  <= '0;
      release_cnt <= '0;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      row_m <= row;
      row_s <= row_m;

      // Dwell only runs while scanning so a resumed scan starts a fresh column.
      if (state != SCAN || dwell_last) dwell <= '0;
      else                             dwell <= dwell + 1'b1;

      if (advance_col) col_idx <= col_idx + 2'd1;

      if (latch_cand) begin
        cand_col <= col_idx;
        cand_row <= first_row;
      end

      if (state != DEBOUNCE)  stable_cnt <= '0;
      else if (cand_low)      stable_cnt <= stable_cnt + 1'b1;

      if (state != HOLD || cand_low) release_cnt <= '0;
      else                           release_cnt <= release_cnt + 1'b1;

      if (accept) key_code <= {cand_col, cand_row};
      key_valid <= accept | repeat_fire;

      if (accept)           key_held <= 1'b1;
      else if (release_key) key_held <= 1'b0;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CNT);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 1);

  logic [REP_W-1:0] rep_cnt;

  assign repeat_fire = (state == HOLD) && cand_low && (rep_cnt == REP_LAST);

  always_ff @(posedge clk) begin
    if (reset)                                     rep_cnt <= '0;
    else if (state != HOLD || !cand_low || repeat_fire) rep_cnt <= '0;
    else                                           rep_cnt <= rep_cnt + 1'b1;
  end
`else
  // Repeat interval has no meaning without auto-repeat.
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CNT;
  assign repeat_fire   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Directed bench for keypad_scanner with a 4x4 key-matrix model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  shift_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] pressed = 16'h0000;
  logic [3:0]  glitch = 4'b1111;

  int passed = 0;
  int total = 0;
  int pulses = 0;
  logic [3:0] last_code = 4'd0;
  logic prev_valid = 1'b0;

`ifdef KEYPAD_REPEAT_EN
  localparam int EXP_T6_PULSES = 6;
`else
  localparam int EXP_T6_PULSES = 1;
`endif

  keypad_scanner #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(8),
    .REPEAT_CNT  (20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .shift_col(shift_col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && !shift_col[c]) row[r] = 1'b0;
    row = row & glitch;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!reset && key_valid) begin
      pulses++;
      last_code = key_code;
      check("valid_not_back_to_back", 32'(prev_valid), 0);
    end
    prev_valid = key_valid & ~reset;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] exp_col;
    logic       exp_valid;
    logic       exp_held;
    logic [3:0] exp_code;
  } vec_t;

  vec_t vecs [19];

  initial begin
    int p0;
    int run;
    int max_run;
    logic [3:0] prev_col;
    logic held_seen;
    logic found;

    vecs = '{
      '{1'b1, 4'b1110, 1'b0, 1'b0, 4'd0},
      '{1'b1, 4'b1110, 1'b0, 1'b0, 4'd0},
      '{1'b1, 4'b1110, 1'b0, 1'b0, 4'd0},
      '{1'b0, 4'b1110, 1'b0, 1'b0, 4'd0},
      '{1'b0, 4'b1110, 1'b0, 1'b0, 4'd0},
      '{1'b0, 4'b1110, 1'b0, 1'b0, 4'd0},
      '{1'b0, 4'b1101, 1'b0, 1'b0, 4'd0},
      '{1'b0, 4'b1101, 1'b0, 1'b0, 4'd0},
      '{1'b0, 4'b1101, 1'b0, 1'b0, 4'd0},
      '{1'b0, 4'b1101, 1'b0, 1'b0, 4'd0},
      '{1'b0, 4'b1011, 1'b0, 1'b0, 4'd0},
      '{1'b0, 4'b1011, 1'b0, 1'b0, 4'd0},
      '{1'b0, 4'b1011, 1'b0, 1'b0, 4'd0},
      '{1'b0, 4'b1011, 1'b0, 1'b0, 4'd0},
      '{1'b0, 4'b0111, 1'b0, 1'b0, 4'd0},
      '{1'b0, 4'b0111, 1'b0, 1'b0, 4'd0},
      '{1'b0, 4'b0111, 1'b0, 1'b0, 4'd0},
      '{1'b0, 4'b0111, 1'b0, 1'b0, 4'd0},
      '{1'b0, 4'b1110, 1'b0, 1'b0, 4'd0}
    };

    // Reset state and free-running scan order
    for (int i = 0; i < 19; i++) begin
      reset = vecs[i].rst;
      tick();
      check($sformatf("vec%0d_shift_col", i), 32'(shift_col), 32'(vecs[i].exp_col));
      check($sformatf("vec%0d_key_valid", i), 32'(key_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_key_held", i),  32'(key_held),  32'(vecs[i].exp_held));
      check($sformatf("vec%0d_key_code", i),  32'(key_code),  32'(vecs[i].exp_code));
    end

    // Key 6 (col 1, row 2) held 40 cycles
    p0 = pulses;
    pressed = 16'h0040;
    for (int i = 0; i < 40; i++) tick();
    check("t2_pulse_count", 32'(pulses - p0), 1);
    check("t2_key_code", 32'(last_code), 6);
    check("t2_held_while_pressed", 32'(key_held), 1);
    check("t2_col_frozen", 32'(shift_col), 32'(4'b1101));
    pressed = 16'h0000;
    for (int i = 0; i < 9; i++) tick();
    check("t2_held_before_release_done", 32'(key_held), 1);
    tick();
    check("t2_held_released", 32'(key_held), 0);
    check("t2_resume_col", 32'(shift_col), 32'(4'b1011));
    check("t2_code_kept_after_release", 32'(key_code), 6);

    // Periodic single-cycle glitches on row 0
    p0 = pulses;
    held_seen = 1'b0;
    run = 0;
    max_run = 0;
    prev_col = shift_col;
    for (int i = 0; i < 300; i++) begin
      glitch = (i % 6 == 0) ? 4'b1110 : 4'b1111;
      tick();
      held_seen |= key_held;
      if (shift_col == prev_col) run++;
      else run = 1;
      if (run > max_run) max_run = run;
      prev_col = shift_col;
    end
    glitch = 4'b1111;
    for (int i = 0; i < 6; i++) tick();
    check("t3_no_pulses", 32'(pulses - p0), 0);
    check("t3_never_held", 32'(held_seen), 0);
    check("t3_freeze_bound", 32'(max_run <= 14), 1);

    // Two rows on column 3: lowest row wins, second key in HOLD ignored
    p0 = pulses;
    pressed = 16'h9000;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (key_held) found = 1'b1;
    end
    check("t4_accept_in_time", 32'(found), 1);
    check("t4_pulse_count", 32'(pulses - p0), 1);
    check("t4_key_code", 32'(key_code), 12);
    pressed = 16'hB000;
    for (int i = 0; i < 20; i++) tick();
    check("t4_second_key_no_event", 32'(pulses - p0), 1);
    check("t4_code_unchanged", 32'(key_code), 12);
    check("t4_still_held", 32'(key_held), 1);
    pressed = 16'h0000;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (!key_held) found = 1'b1;
    end
    check("t4_release_in_time", 32'(found), 1);

    // Reset five stable cycles into debounce of key 1
    reset = 1'b1;
    pressed = 16'h0002;
    for (int i = 0; i < 3; i++) tick();
    p0 = pulses;
    reset = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("t5_col_frozen_in_debounce", 32'(shift_col), 32'(4'b1110));
    check("t5_no_valid_yet", 32'(key_valid), 0);
    reset = 1'b1;
    tick();
    check("t5_rst_shift_col", 32'(shift_col), 32'(4'b1110));
    check("t5_rst_key_code", 32'(key_code), 0);
    check("t5_rst_key_valid", 32'(key_valid), 0);
    check("t5_rst_key_held", 32'(key_held), 0);
    pressed = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("t5_no_event_after_reset", 32'(pulses - p0), 0);
    check("t5_code_still_zero", 32'(key_code), 0);

    // Key 9 held 100 cycles after acceptance
    p0 = pulses;
    pressed = 16'h0200;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (key_valid) found = 1'b1;
    end
    check("t6_accept_in_time", 32'(found), 1);
    for (int i = 0; i < 100; i++) tick();
    check("t6_pulse_count", 32'(pulses - p0), 32'(EXP_T6_PULSES));
    check("t6_key_code", 32'(last_code), 9);
    check("t6_held", 32'(key_held), 1);
    pressed = 16'h0000;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (!key_held) found = 1'b1;
    end
    check("t6_release_in_time", 32'(found), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Front-end stage for the vending_machine controller's 4x4 matrix keypad.
- Drives the active-low column strobes and samples the active-low row returns.
- Synchronises and debounces the rows.
- Emits exactly one single-cycle key event per physical press, carrying a 4-bit key code.
- The vending FSM consumes key_code/key_valid; it never sees raw rows.

Parameters:
SCAN_DIV, 16, clock cycles each column stays driven; minimum 4.
DEBOUNCE_CNT, 1000, consecutive stable cycles required to accept a press or a release; minimum 2.
REPEAT_CNT, 50000, auto-repeat interval in cycles; used only when KEYPAD_REPEAT_EN is defined.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
row  input  4  raw keypad rows, active-low, asynchronous to clk.
shift_col  output  4  column strobe, one-hot active-low (exactly one bit 0 at all times).
key_code  output  4  code of the last accepted key; col_idx*4 + row_idx.
key_valid  output  1  one-cycle pulse when key_code is newly accepted.
key_held  output  1  high while an accepted key is still pressed.

Behaviour:
- Reset values: shift_col=4'b1110, key_code=0, key_valid=0, key_held=0. State=SCAN, all counters 0, synchroniser flops=4'b1111.
- Reset mid-operation has the same effect, including during debounce or hold. No pending event survives reset.
- Synchroniser:
  - row passes through 2 flops to give row_s; latency is 2 cycles.
  - Only row_s is used internally.
- Column order: 1110 -> 1101 -> 1011 -> 0111 -> 1110 (wrap). col_idx is 0..3 respectively.
- Row decode: row_idx is the lowest-index bit of row_s that is 0. Multiple simultaneous rows: lowest index wins.
- SCAN state:
  - dwell counter runs 0..SCAN_DIV-1 per column.
  - row_s is evaluated only when dwell == SCAN_DIV-1.
  - If row_s == 4'b1111: advance to the next column and clear dwell.
  - Otherwise: latch cand_col/cand_row, clear the stable counter, go to DEBOUNCE. shift_col stays frozen on the current column.
- DEBOUNCE state:
  - Each cycle row_s[cand_row]==0: stable counter increments.
  - If row_s[cand_row]==1 on any cycle: glitch. Return to SCAN, advance to the next column, emit no event.
  - When the counter reaches DEBOUNCE_CNT-1 with the row still low:
    - key_code <= {cand_col, cand_row};
    - key_valid = 1 for exactly the next cycle;
    - key_held <= 1;
    - go to HOLD.
- HOLD state:
  - Column stays frozen.
  - Release counter increments while row_s[cand_row]==1 and clears to 0 on any cycle the row is low.
  - When it reaches DEBOUNCE_CNT-1: key_held <= 0, return to SCAN, advance to the next column.
- Other keys pressed during DEBOUNCE or HOLD are ignored. There is no rollover; the second key is detected only after the first is released and rescanned.
- key_code holds its value until the next accepted press. It does not change on release.
- key_valid is never high for two consecutive cycles, except in repeat mode with REPEAT_CNT=1, which is illegal (REPEAT_CNT>=2).
- Worst-case latency from a stable press to key_valid: 4*SCAN_DIV + DEBOUNCE_CNT + 3 cycles.

Optional Feature:
KEYPAD_REPEAT_EN
- Defined:
  - In HOLD, a repeat counter counts cycles while row_s[cand_row] stays low.
  - At REPEAT_CNT-1 it pulses key_valid with the unchanged key_code and restarts from 0.
  - It clears on any high sample and on leaving HOLD.
- Undefined: no repeat counter exists. Exactly one key_valid per press; REPEAT_CNT is unused.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_CNT=20):
1. Reset held 3 cycles, row=1111 -> shift_col=1110, key_code=0, key_valid=0, key_held=0. After release, shift_col cycles 1110,1101,1011,0111,1110 with 4 cycles per column.
2. Hold row=1011 only while shift_col==1101, for 40 cycles -> exactly one key_valid pulse with key_code=6 (col 1, row 2). key_held=1 until 8 cycles after release (plus sync latency), then scanning resumes at 1011.
3. 1-cycle low glitch on row[0], repeated every 6 cycles for 300 cycles -> no key_valid, key_held stays 0, shift_col never freezes longer than 4+8+2 cycles.
4. row=0110 while column 3 is driven, held 30 cycles -> single event with key_code=12 (lowest row wins). A second key pressed during HOLD produces no event.
5. Reset asserted mid-DEBOUNCE (5 stable cycles in) -> no key_valid; outputs return to reset values the next cycle.
6. With KEYPAD_REPEAT_EN defined, key 9 held for 100 cycles after acceptance -> key_valid pulses at acceptance, then every 20 cycles (5 repeats), key_code=9 throughout. Without the macro -> exactly 1 pulse.
